// File: rtl/space_invaders_pkg.sv
// ============================================================================
// Module      : space_invaders_pkg
// Description : Shared edge codes, collision categories and detector states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package space_invaders_pkg;

    localparam logic [3:0] EDGE_LEFT   = 4'h8;
    localparam logic [3:0] EDGE_TOP    = 4'h4;
    localparam logic [3:0] EDGE_RIGHT  = 4'h2;
    localparam logic [3:0] EDGE_BOTTOM = 4'h1;

    // Bit positions of the collision categories inside per-category vectors
    localparam int CAT_PLAYER  = 0;
    localparam int CAT_INVADER = 1;
    localparam int CAT_SHIELD  = 2;
    localparam int CAT_BORDER  = 3;
    localparam int NUM_CATS    = 4;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } collision_state_t;

endpackage

`default_nettype wire

// File: rtl/banana_collision_detector_if.sv
// ============================================================================
// Module      : banana_collision_detector_if
// Description : Scene drawing requests in, per-frame collision report out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface banana_collision_detector_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   startOfFrame;
    logic                   bananaActive;
    logic                   bananaDrawingRequest;
    logic [3:0]             bananaHitEdgeCode;
    logic                   playerDrawingRequest;
    logic                   invadersDrawingRequest;
    logic                   shieldDrawingRequest;
    logic                   borderDrawingRequest;

    logic                   hitPlayer;
    logic                   hitInvader;
    logic                   hitShield;
    logic                   hitBorder;
    logic [3:0]             hitEdgeCode;
    logic [COUNT_WIDTH-1:0] invaderOverlapCount;
    logic                   frameValid;

    modport master (
        output startOfFrame, bananaActive, bananaDrawingRequest, bananaHitEdgeCode,
               playerDrawingRequest, invadersDrawingRequest, shieldDrawingRequest,
               borderDrawingRequest,
        input  hitPlayer, hitInvader, hitShield, hitBorder, hitEdgeCode,
               invaderOverlapCount, frameValid
    );

    modport slave (
        input  startOfFrame, bananaActive, bananaDrawingRequest, bananaHitEdgeCode,
               playerDrawingRequest, invadersDrawingRequest, shieldDrawingRequest,
               borderDrawingRequest,
        output hitPlayer, hitInvader, hitShield, hitBorder, hitEdgeCode,
               invaderOverlapCount, frameValid
    );

endinterface

`default_nettype wire

// File: rtl/frame_event_latch.sv
// ============================================================================
// Module      : frame_event_latch
// Description : Sticky per-frame event flag, reported as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_event_latch (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic evt,
    input  wire logic clear,
    output logic      pulse
);

    logic r_flag;
    logic r_pulse;

    // On clear the finished frame is reported and the new frame starts with
    // this cycle's event already included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
        end else if (clear) begin
            r_pulse <= r_flag;
            r_flag  <= evt;
        end else begin
            r_pulse <= 1'b0;
            r_flag  <= r_flag | evt;
        end
    end

    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/banana_collision_detector.sv
// ============================================================================
// Module      : banana_collision_detector
// Description : Accumulates banana overlaps per frame, reports at next SOF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banana_collision_detector
    import space_invaders_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    banana_collision_detector_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;
    localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    collision_state_t       r_state;
    collision_state_t       w_state_next;
    logic                   w_accepting;
    logic                   w_report;
    logic                   w_banana_on;
    logic [NUM_CATS-1:0]    w_overlap;
    logic [NUM_CATS-1:0]    w_evt;
    logic [NUM_CATS-1:0]    w_pulse;
    logic [3:0]             r_edge_acc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [3:0]             r_hit_edge_code;
    logic [COUNT_WIDTH-1:0] r_overlap_count;
    logic                   r_frame_valid;

    assign w_banana_on             = bus.bananaActive & bus.bananaDrawingRequest;
    assign w_overlap[CAT_PLAYER]   = w_banana_on & bus.playerDrawingRequest;
    assign w_overlap[CAT_INVADER]  = w_banana_on & bus.invadersDrawingRequest;
    assign w_overlap[CAT_SHIELD]   = w_banana_on & bus.shieldDrawingRequest;
    assign w_overlap[CAT_BORDER]   = w_banana_on & bus.borderDrawingRequest;
    assign w_evt                   = w_overlap & {NUM_CATS{w_accepting}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Before the first SOF only the SOF cycle itself is accepted, so the
    // partial frame after reset never reaches a report.
    always_comb begin
        w_state_next = r_state;
        w_accepting  = 1'b0;
        w_report     = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                w_accepting = bus.startOfFrame;
                if (bus.startOfFrame) begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                w_accepting = 1'b1;
                w_report    = bus.startOfFrame;
            end
            default: begin
                w_state_next = WAIT_SOF;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_CATS; gi++) begin : g_latch
        frame_event_latch u_latch (
            .clk   (clk),
            .reset (reset),
            .evt   (w_evt[gi]),
            .clear (bus.startOfFrame),
            .pulse (w_pulse[gi])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_acc      <= 4'h0;
            r_count         <= '0;
            r_hit_edge_code <= 4'h0;
            r_overlap_count <= '0;
            r_frame_valid   <= 1'b0;
        end else begin
            if (bus.startOfFrame) begin
                r_edge_acc <= w_evt[CAT_BORDER] ? bus.bananaHitEdgeCode : 4'h0;
                r_count    <= w_evt[CAT_INVADER] ? c_count_one : '0;
            end else if (r_state == ACCUM) begin
                if (w_evt[CAT_BORDER]) begin
                    r_edge_acc <= r_edge_acc | bus.bananaHitEdgeCode;
                end
                if (w_evt[CAT_INVADER] && (r_count != c_count_max)) begin
                    r_count <= r_count + c_count_one;
                end
            end
            if (w_report) begin
                r_hit_edge_code <= r_edge_acc;
                r_overlap_count <= r_count;
                r_frame_valid   <= 1'b1;
            end
        end
    end

    assign bus.hitPlayer           = w_pulse[CAT_PLAYER];
    assign bus.hitInvader          = w_pulse[CAT_INVADER];
    assign bus.hitShield           = w_pulse[CAT_SHIELD];
    assign bus.hitBorder           = w_pulse[CAT_BORDER];
    assign bus.hitEdgeCode         = r_hit_edge_code;
    assign bus.invaderOverlapCount = r_overlap_count;
    assign bus.frameValid          = r_frame_valid;

endmodule

`default_nettype wire

// File: tb/tb_banana_collision_detector.sv
// ============================================================================
// Module      : tb_banana_collision_detector
// Description : Directed bench for the collision detector at widths 8 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_banana_collision_detector;
    import space_invaders_pkg::*;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sof  = 1'b0;
    logic       act  = 1'b0;
    logic       bdr  = 1'b0;
    logic [3:0] code = 4'h0;
    logic       pl   = 1'b0;
    logic       inv  = 1'b0;
    logic       sh   = 1'b0;
    logic       bo   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    banana_collision_detector_if #(.COUNT_WIDTH(8)) if8 ();
    banana_collision_detector_if #(.COUNT_WIDTH(4)) if4 ();

    assign if8.startOfFrame           = sof;
    assign if8.bananaActive           = act;
    assign if8.bananaDrawingRequest   = bdr;
    assign if8.bananaHitEdgeCode      = code;
    assign if8.playerDrawingRequest   = pl;
    assign if8.invadersDrawingRequest = inv;
    assign if8.shieldDrawingRequest   = sh;
    assign if8.borderDrawingRequest   = bo;
    assign if4.startOfFrame           = sof;
    assign if4.bananaActive           = act;
    assign if4.bananaDrawingRequest   = bdr;
    assign if4.bananaHitEdgeCode      = code;
    assign if4.playerDrawingRequest   = pl;
    assign if4.invadersDrawingRequest = inv;
    assign if4.shieldDrawingRequest   = sh;
    assign if4.borderDrawingRequest   = bo;

    banana_collision_detector #(.COUNT_WIDTH(8)) dut8 (.clk(clk), .reset(rst), .bus(if8.slave));
    banana_collision_detector #(.COUNT_WIDTH(4)) dut4 (.clk(clk), .reset(rst), .bus(if4.slave));

    // Frame model: unbounded counts per frame, saturation applied at compare
    bit         m_run;
    bit [3:0]   m_seen, m_edge, m_ov;
    int         m_cnt;
    bit [3:0]   e_pulse, e_edge;
    int         e_cnt;
    bit         e_valid;

    initial begin
        m_run = 0; m_seen = 0; m_edge = 0; m_ov = 0; m_cnt = 0;
        e_pulse = 0; e_edge = 0; e_cnt = 0; e_valid = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_seen = 0; m_edge = 0; m_cnt = 0;
                e_pulse = 0; e_edge = 0; e_cnt = 0; e_valid = 0;
            end else begin
                m_ov    = (act && bdr) ? {bo, sh, inv, pl} : 4'h0;
                e_pulse = 4'h0;
                if (sof) begin
                    if (m_run) begin
                        e_pulse = m_seen;
                        e_edge  = m_edge;
                        e_cnt   = m_cnt;
                        e_valid = 1'b1;
                    end
                    m_run  = 1'b1;
                    m_seen = m_ov;
                    m_edge = m_ov[3] ? code : 4'h0;
                    m_cnt  = int'(m_ov[1]);
                end else if (m_run) begin
                    m_seen = m_seen | m_ov;
                    if (m_ov[3]) m_edge = m_edge | code;
                    m_cnt = m_cnt + int'(m_ov[1]);
                end
            end
        end
    end

    task automatic check(string name, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp(string tag, logic [3:0] hits, logic [3:0] ec, int cnt, logic fv, int w);
        check({tag, "_pulses"}, int'(hits), int'(e_pulse));
        check({tag, "_edge"},   int'(ec),   int'(e_edge));
        check({tag, "_count"},  cnt,        sat(e_cnt, w));
        check({tag, "_valid"},  int'(fv),   int'(e_valid));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("w8", {if8.hitBorder, if8.hitShield, if8.hitInvader, if8.hitPlayer},
                if8.hitEdgeCode, int'(if8.invaderOverlapCount), if8.frameValid, 8);
            cmp("w4", {if4.hitBorder, if4.hitShield, if4.hitInvader, if4.hitPlayer},
                if4.hitEdgeCode, int'(if4.invaderOverlapCount), if4.frameValid, 4);
        end
    end

    task automatic drive(bit s, bit a, bit b, logic [3:0] c, bit p, bit i, bit h, bit o);
        @(negedge clk);
        sof = s; act = a; bdr = b; code = c; pl = p; inv = i; sh = h; bo = o;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    // Leaves the bench at the negedge right after the SOF edge
    task automatic sof_report();
        drive(1, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", int'(if8.frameValid), 0);
        check("reset_count", int'(if8.invaderOverlapCount), 0);
        check("reset_edge",  int'(if8.hitEdgeCode), 0);

        for (int k = 0; k < 3; k++) drive(0, 1, 1, 4'h0, 1, 0, 0, 0);
        sof_report();
        check("first_sof_player", int'(if8.hitPlayer), 0);
        check("first_sof_valid",  int'(if8.frameValid), 0);
        idle(2);
        sof_report();
        check("first_report_player", int'(if8.hitPlayer), 0);
        check("first_report_valid",  int'(if8.frameValid), 1);

        for (int k = 0; k < 5; k++) drive(0, 1, 1, 4'h0, 0, 1, 0, 0);
        idle(1);
        sof_report();
        check("inv_pulse",    int'(if8.hitInvader), 1);
        check("inv_count",    int'(if8.invaderOverlapCount), 5);
        check("inv_count_w4", int'(if4.invaderOverlapCount), 5);
        check("inv_others",   int'({if8.hitBorder, if8.hitShield, if8.hitPlayer}), 0);
        idle(1);
        check("inv_pulse_one_cycle", int'(if8.hitInvader), 0);
        check("inv_count_held",      int'(if8.invaderOverlapCount), 5);

        drive(0, 1, 1, EDGE_TOP,  0, 0, 0, 1);
        drive(0, 1, 1, EDGE_LEFT, 0, 0, 0, 1);
        sof_report();
        check("border_pulse", int'(if8.hitBorder), 1);
        check("border_edge",  int'(if8.hitEdgeCode), 12);
        idle(2);
        sof_report();
        check("clean_edge",   int'(if8.hitEdgeCode), 0);
        check("clean_border", int'(if8.hitBorder), 0);

        for (int k = 0; k < 4; k++) drive(0, 0, 1, 4'h1, 0, 0, 1, 0);
        sof_report();
        check("inactive_shield", int'(if8.hitShield), 0);
        check("inactive_count",  int'(if8.invaderOverlapCount), 0);

        for (int k = 0; k < 20; k++) drive(0, 1, 1, 4'h0, 0, 1, 0, 0);
        sof_report();
        check("count20_w8", int'(if8.invaderOverlapCount), 20);
        check("count20_w4", int'(if4.invaderOverlapCount), 15);

        idle(2);
        drive(1, 1, 1, 4'h0, 1, 0, 0, 0);
        idle(1);
        check("sof_overlap_first", int'(if8.hitPlayer), 0);
        idle(2);
        sof_report();
        check("sof_overlap_second", int'(if8.hitPlayer), 1);

        drive(1, 1, 1, 4'h0, 0, 1, 0, 0);
        drive(1, 0, 0, 4'h0, 0, 0, 0, 0);
        idle(1);
        check("b2b_invader", int'(if8.hitInvader), 1);
        check("b2b_count",   int'(if8.invaderOverlapCount), 1);

        for (int k = 0; k < 2; k++) drive(0, 1, 1, 4'h0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 4'h0, 0, 0, 1, 0);
        sof_report();
        check("active_drop_shield", int'(if8.hitShield), 1);

        for (int k = 0; k < 3; k++) drive(0, 1, 1, 4'h0, 1, 0, 0, 0);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("midreset_valid", int'(if8.frameValid), 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) drive(0, 1, 1, 4'h0, 1, 0, 0, 0);
        sof_report();
        check("midreset_player", int'(if8.hitPlayer), 0);
        check("midreset_nvalid", int'(if8.frameValid), 0);
        for (int k = 0; k < 2; k++) drive(0, 1, 1, 4'h0, 1, 0, 0, 0);
        sof_report();
        check("after_reset_player", int'(if8.hitPlayer), 1);
        check("after_reset_valid",  int'(if8.frameValid), 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
